// File: rtl/sdram_arbiter_if.sv
// Bus bundle shared by the requester ports, the SDRAM arbiter and the SDRAM controller.
interface sdram_arbiter_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*26-1:0] req_addr;
    logic [NUM_REQ-1:0]    req_write;
    logic [NUM_REQ*32-1:0] req_wdata;
    logic [NUM_REQ*4-1:0]  req_byte_en;
    logic [NUM_REQ-1:0]    req_ack;
    logic [31:0]           req_rdata;
    logic [NUM_REQ-1:0]    req_rdvalid;
    logic [NUM_REQ-1:0]    req_complete;

    logic                  sdram_req;
    logic [25:0]           sdram_addr;
    logic                  sdram_write;
    logic [31:0]           sdram_wdata;
    logic [3:0]            sdram_byte_en;
    logic                  sdram_ack;
    logic [31:0]           sdram_rdata;
    logic                  sdram_rdvalid;
    logic                  sdram_complete;

    // Arbiter side
    modport master (
        input  req_valid, req_addr, req_write, req_wdata, req_byte_en,
        output req_ack, req_rdata, req_rdvalid, req_complete,
        output sdram_req, sdram_addr, sdram_write, sdram_wdata, sdram_byte_en,
        input  sdram_ack, sdram_rdata, sdram_rdvalid, sdram_complete
    );

    // Requesters plus controller side
    modport slave (
        output req_valid, req_addr, req_write, req_wdata, req_byte_en,
        input  req_ack, req_rdata, req_rdvalid, req_complete,
        input  sdram_req, sdram_addr, sdram_write, sdram_wdata, sdram_byte_en,
        output sdram_ack, sdram_rdata, sdram_rdvalid, sdram_complete
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Single-outstanding SDRAM port arbiter: port 0 fixed priority, ports 1..NUM_REQ-1 round-robin.
module sdram_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic           clk,
    input  logic           reset,
    sdram_arbiter_if.master bus
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, REQ, BUSY} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             sdram_req_q, sdram_req_d;
    logic [25:0]      addr_q, addr_d;
    logic             write_q, write_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       be_q, be_d;

    logic             grant_vld;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] cand_idx;
    int               cand;
    logic [NUM_REQ-1:0] owner_oh;

    // Round-robin scan starts at rr_ptr and wraps over 1..NUM_REQ-1 only.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        cand_idx  = '0;
        if (bus.req_valid[0]) begin
            grant_vld = 1'b1;
        end else begin
            for (int k = 0; k < NUM_REQ - 1; k++) begin
                cand     = ((int'(rr_ptr_q) - 1 + k) % (NUM_REQ - 1)) + 1;
                cand_idx = IDX_W'(cand);
                if (!grant_vld && bus.req_valid[cand_idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand_idx;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            owner_oh[i] = (owner_q == IDX_W'(i));
        end
    end

    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        rr_ptr_d         = rr_ptr_q;
        sdram_req_d      = sdram_req_q;
        addr_d           = addr_q;
        write_d          = write_q;
        wdata_d          = wdata_q;
        be_d             = be_q;
        bus.req_ack      = '0;
        bus.req_rdvalid  = '0;
        bus.req_complete = '0;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    state_d     = REQ;
                    owner_d     = grant_idx;
                    sdram_req_d = 1'b1;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (grant_idx == IDX_W'(i)) begin
                            addr_d  = bus.req_addr[i*26 +: 26];
                            write_d = bus.req_write[i];
                            wdata_d = bus.req_wdata[i*32 +: 32];
                            be_d    = bus.req_byte_en[i*4 +: 4];
                        end
                    end
                end
            end
            REQ: begin
                if (bus.sdram_ack) begin
                    bus.req_ack = owner_oh;
                    sdram_req_d = 1'b0;
                    // Fairness only advances when a shared port is actually accepted.
                    if (owner_q != '0) begin
                        rr_ptr_d = (int'(owner_q) == NUM_REQ - 1) ? IDX_W'(1) : owner_q + 1'b1;
                    end
                    if (bus.sdram_complete) begin
                        bus.req_complete = owner_oh;
                        state_d          = IDLE;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                bus.req_rdvalid = bus.sdram_rdvalid ? owner_oh : '0;
                if (bus.sdram_complete) begin
                    bus.req_complete = owner_oh;
                    state_d          = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= IDX_W'(1);
            sdram_req_q <= 1'b0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            be_q        <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            sdram_req_q <= sdram_req_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
        end
    end

    assign bus.req_rdata     = bus.sdram_rdata;
    assign bus.sdram_req     = sdram_req_q;
    assign bus.sdram_addr    = addr_q;
    assign bus.sdram_write   = write_q;
    assign bus.sdram_wdata   = wdata_q;
    assign bus.sdram_byte_en = be_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Randomised bench for sdram_arbiter; the bench plays requesters and SDRAM controller.
module tb_sdram_arbiter;
    localparam int NUM_REQ = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sdram_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();
    sdram_arbiter #(.NUM_REQ(NUM_REQ)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        bit                 timeout;
        int                 wait_cyc;
        logic [25:0]        addr;
        logic               wr;
        logic [31:0]        wdata;
        logic [3:0]         be;
        bit                 held;
        bit                 req_dropped;
        logic [NUM_REQ-1:0] ack;
        logic [NUM_REQ-1:0] cmpl;
        logic [NUM_REQ-1:0] rdv_or;
        logic [NUM_REQ-1:0] rdv_and;
        int                 data_ok;
    } obs_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          m_ptr    = 1;
    logic [25:0] p_addr [NUM_REQ];

    // Reference arbitration: VGA first, else the next asking shared port from the pointer on.
    function automatic int predict(input logic [NUM_REQ-1:0] pend, input int ptr);
        if (pend[0]) return 0;
        for (int k = 0; k < NUM_REQ - 1; k++) begin
            int p = ptr + k;
            if (p > NUM_REQ - 1) p = p - (NUM_REQ - 1);
            if (pend[p]) return p;
        end
        return -1;
    endfunction

    function automatic void model_grant(input int p);
        if (p != 0) m_ptr = (p == NUM_REQ - 1) ? 1 : p + 1;
    endfunction

    function automatic logic [NUM_REQ-1:0] oh(input int p);
        return NUM_REQ'(1) << p;
    endfunction

    task automatic set_port(input int p, input logic [25:0] a, input logic w,
                            input logic [31:0] d, input logic [3:0] be);
        p_addr[p]                  = a;
        bus.req_addr[p*26 +: 26]   = a;
        bus.req_write[p]           = w;
        bus.req_wdata[p*32 +: 32]  = d;
        bus.req_byte_en[p*4 +: 4]  = be;
    endtask

    // Controller behaviour for one transaction; records what the arbiter showed, no judging here.
    task automatic serve(input int beats, input bit ack_cmpl, input int req_wait,
                         input logic [NUM_REQ-1:0] raise_in_busy, output obs_t o);
        logic [31:0] d;
        o.timeout = 0; o.wait_cyc = 0; o.addr = '0; o.wr = 0; o.wdata = '0; o.be = '0;
        o.held = 1; o.req_dropped = 0; o.ack = '0; o.cmpl = '0; o.rdv_or = '0;
        o.rdv_and = '1; o.data_ok = 0;
        while (bus.sdram_req !== 1'b1 && o.wait_cyc < 20) begin
            @(negedge clk);
            o.wait_cyc++;
        end
        if (bus.sdram_req !== 1'b1) begin
            o.timeout = 1;
            return;
        end
        o.addr = bus.sdram_addr; o.wr = bus.sdram_write;
        o.wdata = bus.sdram_wdata; o.be = bus.sdram_byte_en;
        repeat (req_wait) begin
            @(negedge clk);
            if (bus.sdram_req !== 1'b1 || bus.sdram_addr !== o.addr || bus.sdram_write !== o.wr ||
                bus.sdram_wdata !== o.wdata || bus.sdram_byte_en !== o.be) o.held = 0;
        end
        bus.sdram_ack = 1'b1;
        bus.sdram_complete = ack_cmpl;
        #1;
        o.ack  = bus.req_ack;
        o.cmpl = bus.req_complete;
        @(negedge clk);
        bus.sdram_ack = 1'b0;
        bus.sdram_complete = 1'b0;
        o.req_dropped = (bus.sdram_req === 1'b0);
        bus.req_valid = (bus.req_valid & ~o.ack) | raise_in_busy;
        if (!ack_cmpl) begin
            for (int b = 0; b < beats; b++) begin
                d = $urandom;
                bus.sdram_rdata = d;
                bus.sdram_rdvalid = 1'b1;
                #1;
                o.rdv_or  = o.rdv_or | bus.req_rdvalid;
                o.rdv_and = o.rdv_and & bus.req_rdvalid;
                if (bus.req_rdata === d) o.data_ok++;
                @(negedge clk);
                bus.sdram_rdvalid = 1'b0;
            end
            bus.sdram_complete = 1'b1;
            #1;
            o.cmpl = bus.req_complete;
            @(negedge clk);
            bus.sdram_complete = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (bus.sdram_req !== 1'b0) begin
            n_fail++; $display("FAIL reset_sdram_req: got %b expected 0", bus.sdram_req);
        end
        n_checks++;
        if ({bus.sdram_addr, bus.sdram_write, bus.sdram_wdata, bus.sdram_byte_en} !== '0) begin
            n_fail++; $display("FAIL reset_sdram_bus: addr %h wr %b wdata %h be %b expected all 0",
                               bus.sdram_addr, bus.sdram_write, bus.sdram_wdata, bus.sdram_byte_en);
        end
        n_checks++;
        if ({bus.req_ack, bus.req_rdvalid, bus.req_complete} !== '0) begin
            n_fail++; $display("FAIL reset_req_strobes: ack %b rdv %b cmpl %b expected 0",
                               bus.req_ack, bus.req_rdvalid, bus.req_complete);
        end
        m_ptr = 1;
    endtask

    task automatic test_simultaneous();
        obs_t o;
        int   exp;
        set_port(0, 26'h0000100, 1'b0, '0, 4'hF);
        set_port(1, 26'h0000200, 1'b0, '0, 4'hF);
        set_port(2, 26'h0000300, 1'b0, '0, 4'hF);
        bus.req_valid = 3'b111;
        for (int t = 0; t < 3; t++) begin
            exp = predict(bus.req_valid, m_ptr);
            serve($urandom_range(1, 4), 1'b0, $urandom_range(0, 2), '0, o);
            n_checks++;
            if (o.timeout || o.addr !== p_addr[exp]) begin
                n_fail++; $display("FAIL simul_grant%0d: got addr %h (timeout %0d) expected %h",
                                   t, o.addr, o.timeout, p_addr[exp]);
            end
            n_checks++;
            if (o.wait_cyc != 1) begin
                n_fail++; $display("FAIL simul_bubble%0d: got %0d cycles expected 1", t, o.wait_cyc);
            end
            n_checks++;
            if (o.ack !== oh(exp) || o.cmpl !== oh(exp)) begin
                n_fail++; $display("FAIL simul_ack_cmpl%0d: ack %b cmpl %b expected %b",
                                   t, o.ack, o.cmpl, oh(exp));
            end
            model_grant(exp);
        end
    endtask

    task automatic test_round_robin();
        obs_t o;
        int   exp;
        set_port(1, 26'h0011000, 1'b0, '0, 4'hF);
        set_port(2, 26'h0022000, 1'b0, '0, 4'hF);
        bus.req_valid = 3'b110;
        for (int t = 0; t < 6; t++) begin
            exp = predict(bus.req_valid, m_ptr);
            serve($urandom_range(1, 3), 1'b0, $urandom_range(0, 1), '0, o);
            n_checks++;
            if (o.timeout || o.addr !== p_addr[exp] || o.ack !== oh(exp)) begin
                n_fail++; $display("FAIL rr_grant%0d: got addr %h ack %b expected addr %h ack %b",
                                   t, o.addr, o.ack, p_addr[exp], oh(exp));
            end
            model_grant(exp);
            bus.req_valid = bus.req_valid | 3'b110;
        end
        bus.req_valid = '0;
    endtask

    task automatic test_single_read();
        obs_t o;
        int   exp;
        set_port(1, 26'h0001000, 1'b0, 32'h12345678, 4'hF);
        bus.req_valid = 3'b010;
        exp = predict(bus.req_valid, m_ptr);
        serve(4, 1'b0, 1, '0, o);
        n_checks++;
        if (o.timeout || o.wait_cyc != 1) begin
            n_fail++; $display("FAIL read_req_latency: got %0d cycles (timeout %0d) expected 1",
                               o.wait_cyc, o.timeout);
        end
        n_checks++;
        if (o.addr !== 26'h0001000 || o.wr !== 1'b0) begin
            n_fail++; $display("FAIL read_addr: got %h wr %b expected 0001000 wr 0", o.addr, o.wr);
        end
        n_checks++;
        if (o.ack !== oh(exp)) begin
            n_fail++; $display("FAIL read_ack: got %b expected %b", o.ack, oh(exp));
        end
        n_checks++;
        if (!o.req_dropped) begin
            n_fail++; $display("FAIL read_req_drop: sdram_req still 1 after ack, expected 0");
        end
        n_checks++;
        if (o.rdv_or !== oh(exp) || o.rdv_and !== oh(exp) || o.data_ok != 4) begin
            n_fail++; $display("FAIL read_beats: rdv_or %b rdv_and %b data_ok %0d expected %b %b 4",
                               o.rdv_or, o.rdv_and, o.data_ok, oh(exp), oh(exp));
        end
        n_checks++;
        if (o.cmpl !== oh(exp)) begin
            n_fail++; $display("FAIL read_complete: got %b expected %b", o.cmpl, oh(exp));
        end
        model_grant(exp);
    endtask

    task automatic test_port0_no_preempt();
        obs_t o;
        int   exp;
        set_port(0, 26'h0000ABC, 1'b0, '0, 4'hF);
        set_port(1, 26'h0001DEF, 1'b0, '0, 4'hF);
        set_port(2, 26'h0002468, 1'b0, '0, 4'hF);
        bus.req_valid = 3'b100;
        exp = predict(bus.req_valid, m_ptr);
        serve(3, 1'b0, 0, 3'b011, o);
        n_checks++;
        if (o.addr !== p_addr[exp] || o.rdv_or !== oh(exp) || o.cmpl !== oh(exp)) begin
            n_fail++; $display("FAIL busy_port2: addr %h rdv %b cmpl %b expected %h %b %b",
                               o.addr, o.rdv_or, o.cmpl, p_addr[exp], oh(exp), oh(exp));
        end
        model_grant(exp);
        for (int t = 0; t < 2; t++) begin
            exp = predict(bus.req_valid, m_ptr);
            serve(1, 1'b0, 0, '0, o);
            n_checks++;
            if (o.timeout || o.addr !== p_addr[exp] || o.ack !== oh(exp)) begin
                n_fail++; $display("FAIL after_busy_grant%0d: addr %h ack %b expected %h %b",
                                   t, o.addr, o.ack, p_addr[exp], oh(exp));
            end
            model_grant(exp);
        end
    endtask

    task automatic test_write_ack_complete();
        obs_t o;
        int   exp;
        set_port(2, 26'h3ABCDEF, 1'b1, 32'hDEADBEEF, 4'b0101);
        bus.req_valid = 3'b100;
        exp = predict(bus.req_valid, m_ptr);
        serve(0, 1'b1, 3, '0, o);
        n_checks++;
        if (o.addr !== 26'h3ABCDEF || o.wr !== 1'b1 || o.wdata !== 32'hDEADBEEF || o.be !== 4'b0101) begin
            n_fail++; $display("FAIL write_fields: addr %h wr %b wdata %h be %b expected 3abcdef 1 deadbeef 0101",
                               o.addr, o.wr, o.wdata, o.be);
        end
        n_checks++;
        if (!o.held) begin
            n_fail++; $display("FAIL write_hold: sdram outputs changed before ack, expected stable");
        end
        n_checks++;
        if (o.ack !== oh(exp) || o.cmpl !== oh(exp)) begin
            n_fail++; $display("FAIL write_same_cycle: ack %b cmpl %b expected %b %b",
                               o.ack, o.cmpl, oh(exp), oh(exp));
        end
        model_grant(exp);
        bus.sdram_rdvalid = 1'b1;
        #1;
        n_checks++;
        if (bus.req_rdvalid !== '0 || bus.sdram_req !== 1'b0) begin
            n_fail++; $display("FAIL write_back_to_idle: rdvalid %b sdram_req %b expected 0 0",
                               bus.req_rdvalid, bus.sdram_req);
        end
        @(negedge clk);
        bus.sdram_rdvalid = 1'b0;
    endtask

    task automatic test_reset_busy();
        int n;
        set_port(1, 26'h1555555, 1'b0, '0, 4'hF);
        bus.req_valid = 3'b010;
        n = 0;
        while (bus.sdram_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus.sdram_ack = 1'b1;
        @(negedge clk);
        bus.sdram_ack = 1'b0;
        bus.req_valid = '0;
        bus.sdram_rdvalid = 1'b1;
        #1;
        n_checks++;
        if (bus.req_rdvalid !== 3'b010) begin
            n_fail++; $display("FAIL rst_busy_routed: got %b expected 010", bus.req_rdvalid);
        end
        @(negedge clk);
        bus.sdram_rdvalid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if ({bus.sdram_req, bus.sdram_addr, bus.sdram_write, bus.sdram_wdata, bus.sdram_byte_en} !== '0) begin
            n_fail++; $display("FAIL rst_busy_outputs: req %b addr %h expected all 0", bus.sdram_req, bus.sdram_addr);
        end
        bus.sdram_rdvalid = 1'b1;
        bus.sdram_complete = 1'b1;
        #1;
        n_checks++;
        if ({bus.req_ack, bus.req_rdvalid, bus.req_complete} !== '0) begin
            n_fail++; $display("FAIL rst_busy_stray: ack %b rdv %b cmpl %b expected 0",
                               bus.req_ack, bus.req_rdvalid, bus.req_complete);
        end
        @(negedge clk);
        bus.sdram_rdvalid = 1'b0;
        bus.sdram_complete = 1'b0;
        m_ptr = 1;
    endtask

    task automatic test_random();
        obs_t               o;
        int                 exp, beats;
        bit                 ac;
        logic [NUM_REQ-1:0] newreq;
        for (int t = 0; t < 40; t++) begin
            newreq = NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1)) & ~bus.req_valid;
            if ((bus.req_valid | newreq) == '0) newreq = oh($urandom_range(0, NUM_REQ - 1));
            for (int p = 0; p < NUM_REQ; p++) begin
                if (newreq[p]) set_port(p, {p[2:0], 23'($urandom)}, 1'($urandom), $urandom, 4'($urandom));
            end
            bus.req_valid = bus.req_valid | newreq;
            exp = predict(bus.req_valid, m_ptr);
            if (bus.req_write[exp]) begin
                beats = 0; ac = 1'($urandom);
            end else begin
                beats = $urandom_range(1, 4); ac = 1'b0;
            end
            serve(beats, ac, $urandom_range(0, 2), '0, o);
            n_checks++;
            if (o.timeout || o.wait_cyc != 1 || o.addr !== p_addr[exp] || o.wr !== bus.req_write[exp]) begin
                n_fail++; $display("FAIL rand_grant%0d: addr %h wr %b wait %0d expected %h %b 1",
                                   t, o.addr, o.wr, o.wait_cyc, p_addr[exp], bus.req_write[exp]);
            end
            n_checks++;
            if (o.ack !== oh(exp) || o.cmpl !== oh(exp)) begin
                n_fail++; $display("FAIL rand_ack_cmpl%0d: ack %b cmpl %b expected %b",
                                   t, o.ack, o.cmpl, oh(exp));
            end
            if (beats > 0) begin
                n_checks++;
                if (o.rdv_or !== oh(exp) || o.rdv_and !== oh(exp) || o.data_ok != beats) begin
                    n_fail++; $display("FAIL rand_rdata%0d: rdv %b/%b ok %0d expected %b %0d",
                                       t, o.rdv_or, o.rdv_and, o.data_ok, oh(exp), beats);
                end
            end
            model_grant(exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.req_valid = '0; bus.req_addr = '0; bus.req_write = '0;
        bus.req_wdata = '0; bus.req_byte_en = '0;
        bus.sdram_ack = 1'b0; bus.sdram_rdata = '0;
        bus.sdram_rdvalid = 1'b0; bus.sdram_complete = 1'b0;
        test_reset();
        test_simultaneous();
        test_round_robin();
        test_single_read();
        test_port0_no_preempt();
        test_write_ack_complete();
        test_reset_busy();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single SDRAM controller port between NUM_REQ requesters: VGA pixel fetch, CPU data cache and blitter.
- Port 0 is the VGA path and has fixed highest priority, because display underrun is visible on screen.
- Ports 1..NUM_REQ-1 share the remaining bandwidth round-robin.
- Exactly one transaction is outstanding at a time. Read data and completion are routed back only to the port that owns the current transaction.

Parameters:
- NUM_REQ, 3, number of requester ports (2..8); port 0 is the priority (VGA) port.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-port request; must be held until the matching req_ack
- req_addr  in  NUM_REQ*26  per-port 26-bit byte address; port i uses bits [26i+25:26i]
- req_write  in  NUM_REQ  per-port 1 = write, 0 = read
- req_wdata  in  NUM_REQ*32  per-port write data
- req_byte_en  in  NUM_REQ*4  per-port write byte enables
- req_ack  out  NUM_REQ  one-cycle accept pulse to the owning port
- req_rdata  out  32  read data, broadcast to all ports
- req_rdvalid  out  NUM_REQ  read-data strobe to the owning port only
- req_complete  out  NUM_REQ  end-of-transaction pulse to the owning port only
- sdram_req  out  1  request to the SDRAM controller
- sdram_addr  out  26  address to the controller
- sdram_write  out  1  write flag to the controller
- sdram_wdata  out  32  write data to the controller
- sdram_byte_en  out  4  byte enables to the controller
- sdram_ack  in  1  controller accepted the request
- sdram_rdata  in  32  controller read data
- sdram_rdvalid  in  1  controller read-data strobe (one or more beats per read)
- sdram_complete  in  1  controller transaction done

Behaviour:

Reset:
- state=IDLE, owner=0, rr_ptr=1.
- sdram_req=0; sdram_addr, sdram_wdata, sdram_byte_en, sdram_write = 0.
- All req_ack, req_rdvalid, req_complete = 0.
- Reset mid-transaction abandons the transaction: no complete is issued to the owner, and the controller is reset by the same signal.

State machine IDLE / REQ / BUSY:

IDLE:
- Port 0 wins if req_valid[0] is high.
- Otherwise the first asserted port scanning rr_ptr, rr_ptr+1, … (wrapping over 1..NUM_REQ-1) wins.
- On a winner, register owner and latch that port's addr/write/wdata/byte_en into the sdram_* outputs, set sdram_req=1, and go to REQ.
- sdram_req therefore rises exactly 1 cycle after req_valid is seen in IDLE.

REQ:
- Hold sdram_req and all sdram_* outputs stable.
- On sdram_ack: sdram_req goes 0 next cycle; req_ack[owner]=sdram_ack combinationally in the same cycle; go to BUSY.
- If sdram_complete arrives in the same cycle as sdram_ack, go to IDLE instead and pulse req_complete[owner].
- When a round-robin port (owner≠0) is acked, rr_ptr <= owner+1, wrapping to 1 after NUM_REQ-1.

BUSY:
- req_rdvalid[owner]=sdram_rdvalid and req_rdata=sdram_rdata, both combinational; all other rdvalid bits stay 0.
- On sdram_complete: req_complete[owner]=1 combinationally, go to IDLE.

Throughput and ordering rules:
- Back-to-back transactions have one IDLE bubble cycle between complete and the next sdram_req.
- Arbitration happens only in IDLE. A port-0 request arriving during REQ/BUSY does not pre-empt; it wins at the next IDLE.
- The rr_ptr update on ack is the only fairness state. Port 0 can starve ports 1..N-1 only if it requests continuously; this is accepted by design.

Error handling:
- sdram_rdvalid, sdram_complete or sdram_ack outside the states above are ignored and never routed to any port.
- req_valid dropped before ack is a protocol violation. The arbiter still completes the transaction and pulses ack/complete to that port.

Widths: all addresses are 26 bits and no arithmetic is done on them. rr_ptr is $clog2(NUM_REQ) bits.

Test Plan:
- Reset, then single read on port 1 at addr 0x0001000: sdram_req rises 1 cycle after req_valid with sdram_addr=0x0001000. Ack returns req_ack[1] the same cycle. Four rdvalid beats appear only on req_rdvalid[1] with the matching data; req_complete[1] pulses once.
- Ports 0, 1 and 2 request in the same IDLE cycle: grant order is 0, 1, 2, with one idle cycle between each complete and the next sdram_req.
- Ports 1 and 2 request continuously for 6 transactions: grants alternate 1, 2, 1, 2, 1, 2.
- Port 0 raises req_valid while port 2 is in BUSY: port 2 completes undisturbed, then port 0 is granted ahead of a pending port 1.
- Write on port 2 with wdata=0xDEADBEEF, byte_en=4'b0101: the sdram_* outputs hold those values until ack. Ack and complete arriving in the same cycle return to IDLE and pulse req_complete[2].
- Reset asserted in BUSY: the next cycle shows all outputs 0 and state IDLE. A stray sdram_rdvalid afterwards produces no req_rdvalid.
